// File: rtl/seq_det_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl_if
//   Bundles every non-clock signal of the sequence-detector frame controller:
//   the word-input handshake, the serial detector link and the result
//   handshake.
//
//   Signals
//     s_valid / s_ready / s_data      : input word handshake (MSB scanned first)
//     det_reset / det_in / det_out    : link to the serial Moore detector
//     m_valid / m_ready               : result handshake
//     m_hit_mask / m_count            : per-bit hit mask and saturating count
//
//   Modports
//     master : the controller side (owns s_ready, the detector drive and the
//              result outputs)
//     slave  : the surrounding producer / detector / consumer side
// ---------------------------------------------------------------------------
interface seq_det_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  logic              det_reset;
  logic              det_in;
  logic              det_out;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_hit_mask;
  logic [CNT_W-1:0]  m_count;

  modport master (
    input  s_valid,
    input  s_data,
    input  det_out,
    input  m_ready,
    output s_ready,
    output det_reset,
    output det_in,
    output m_valid,
    output m_hit_mask,
    output m_count
  );

  modport slave (
    output s_valid,
    output s_data,
    output det_out,
    output m_ready,
    input  s_ready,
    input  det_reset,
    input  det_in,
    input  m_valid,
    input  m_hit_mask,
    input  m_count
  );

endinterface

// File: rtl/seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_ctrl
//   Frame controller for a serial Moore sequence detector. A DATA_W-bit word
//   is accepted over a valid/ready handshake, optionally the detector is
//   cleared for one cycle, then the word is shifted out MSB first, one bit
//   per cycle. The detector output is sampled one cycle after each bit (its
//   output is registered), building a per-bit hit mask and a saturating hit
//   count that are returned over a second valid/ready handshake.
//
//   Parameters
//     DATA_W          : bits per frame (>= 2)
//     CNT_W           : hit count width, saturates at 2**CNT_W-1
//     CLEAR_PER_FRAME : 1 = pulse det_reset before every frame,
//                       0 = detector state carries across frames
//
//   Ports
//     clk   : single clock, rising edge
//     reset : synchronous, active-high; aborts any frame in flight and also
//             resets the detector in the same cycle
//     bus   : seq_det_ctrl_if.master (word in, detector link, result out)
//
//   Latency from the acceptance cycle to the first m_valid cycle is
//   DATA_W+3 cycles with CLEAR_PER_FRAME=1 and DATA_W+2 cycles otherwise.
// ---------------------------------------------------------------------------
module seq_det_ctrl #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned CNT_W           = 4,
  parameter bit          CLEAR_PER_FRAME = 1'b1
) (
  input logic           clk,
  input logic           reset,
  seq_det_ctrl_if.master bus
);

  localparam int unsigned        IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] mask_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              sample;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      idx   <= idx_next;
      mask  <= mask_next;
      cnt   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = idx;
    sample     = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.s_valid) begin
          shreg_next = bus.s_data;
          idx_next   = '0;
          state_next = CLEAR_PER_FRAME ? CLR : SHIFT;
        end
      end

      CLR: begin
        state_next = SHIFT;
      end

      SHIFT: begin
        shreg_next = {shreg[DATA_W-2:0], 1'b0};
        // The first SHIFT cycle's det_out still reflects pre-frame history.
        sample     = (idx != '0);
        if (idx == IDX_LAST) begin
          idx_next   = '0;
          state_next = DRAIN;
        end else begin
          idx_next   = idx + IDX_W'(1);
        end
      end

      DRAIN: begin
        sample     = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        if (bus.m_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Samples arrive in bit order DATA_W-1 down to 0, so shifting each one in
  // at the LSB lands the first sample at the MSB after exactly DATA_W samples
  // (DATA_W-1 in SHIFT plus one in DRAIN) without any index decode.
  always_comb begin
    mask_next = mask;
    cnt_next  = cnt;

    if (state == IDLE && bus.s_valid) begin
      mask_next = '0;
      cnt_next  = '0;
    end else if (sample) begin
      mask_next = {mask[DATA_W-2:0], bus.det_out};
      if (bus.det_out && (cnt != CNT_MAX)) begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.s_ready    = (state == IDLE) && !reset;
  assign bus.det_reset  = reset || (state == CLR);
  assign bus.det_in     = (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;
  assign bus.m_valid    = (state == DONE);
  assign bus.m_hit_mask = mask;
  assign bus.m_count    = cnt;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_ctrl
//   Two controllers run side by side on the same word stream:
//     dut_a : CNT_W=4, CLEAR_PER_FRAME=1
//     dut_b : CNT_W=1, CLEAR_PER_FRAME=0 (count saturates after one hit)
//   Each drives its own emulated non-overlapping Moore "1010" detector.
//   Expected results are computed per word by scanning the bit string for
//   non-overlapping "1010" occurrences. Between frames the detector always
//   sees at least two zeros (DRAIN, DONE, IDLE), and any two zeros return a
//   "1010" detector to its start state, so each frame scores independently
//   of earlier frames even when the detector is not cleared.
// ---------------------------------------------------------------------------
module tb_seq_det_ctrl;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W_A = 4;
  localparam int unsigned CNT_W_B = 1;
  localparam int unsigned LAT_A   = DATA_W + 3;
  localparam int unsigned LAT_B   = DATA_W + 2;

  typedef struct {
    logic [DATA_W-1:0] mask;
    int unsigned       cnt;
    int unsigned       t_acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;
  int          bp_mode = 1;   // 0: random m_ready, 1: hold low, 2: hold high
  exp_t        exp_a[$];
  exp_t        exp_b[$];
  bit          seen_a = 1'b0;
  bit          seen_b = 1'b0;
  int unsigned det_a_st = 0;
  int unsigned det_b_st = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W_A)) bus_a ();
  seq_det_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W_B)) bus_b ();

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W_A), .CLEAR_PER_FRAME(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W_B), .CLEAR_PER_FRAME(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Emulated detector: progress through "1010", restarting after a full match.
  function automatic int unsigned det_step(input int unsigned st, input logic b);
    case (st)
      0:       det_step = b ? 1 : 0;
      1:       det_step = b ? 1 : 2;
      2:       det_step = b ? 3 : 0;
      3:       det_step = b ? 1 : 4;
      default: det_step = b ? 1 : 0;
    endcase
  endfunction

  always @(posedge clk) det_a_st <= bus_a.det_reset ? 0 : det_step(det_a_st, bus_a.det_in);
  always @(posedge clk) det_b_st <= bus_b.det_reset ? 0 : det_step(det_b_st, bus_b.det_in);
  assign bus_a.det_out = (det_a_st == 4);
  assign bus_b.det_out = (det_b_st == 4);

  // Reference: scan MSB first, a hit is the bit completing "1010" counted
  // only among bits since the previous hit.
  function automatic void ref_frame(input logic [DATA_W-1:0] w, input int unsigned cnt_w,
                                    output logic [DATA_W-1:0] mask, output int unsigned cnt);
    logic [3:0]  win;
    int unsigned len;
    int unsigned hits;
    int unsigned cmax;
    win  = '0;
    len  = 0;
    hits = 0;
    mask = '0;
    cmax = (1 << cnt_w) - 1;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      win = {win[2:0], w[i]};
      len++;
      if (len >= 4 && win == 4'b1010) begin
        mask[i] = 1'b1;
        hits++;
        len = 0;
      end
    end
    cnt = (hits > cmax) ? cmax : hits;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor(input int unsigned which, input logic mv, input logic mr, input logic sr,
                         input logic [DATA_W-1:0] mask, input logic [31:0] cnt);
    exp_t        e;
    string       tag;
    int unsigned lat;
    tag = (which == 0) ? "a" : "b";
    lat = (which == 0) ? LAT_A : LAT_B;
    if (mv) begin
      check({tag, ".s_ready_in_done"}, {31'd0, sr}, 32'd0);
      if ((which == 0 && exp_a.size() == 0) || (which == 1 && exp_b.size() == 0)) begin
        checks++;
        fails++;
        $display("FAIL %s.unexpected_m_valid: got m_valid=1 expected 0 (cycle %0d)", tag, cyc);
      end else begin
        e = (which == 0) ? exp_a[0] : exp_b[0];
        if ((which == 0 && !seen_a) || (which == 1 && !seen_b)) begin
          check({tag, ".latency"}, cyc - e.t_acc, lat);
          if (which == 0) seen_a = 1'b1; else seen_b = 1'b1;
        end
        check({tag, ".m_hit_mask"}, {24'd0, mask}, {24'd0, e.mask});
        check({tag, ".m_count"}, cnt, e.cnt);
        if (mr) begin
          if (which == 0) begin void'(exp_a.pop_front()); seen_a = 1'b0; end
          else            begin void'(exp_b.pop_front()); seen_b = 1'b0; end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, bus_a.m_valid, bus_a.m_ready, bus_a.s_ready, bus_a.m_hit_mask, 32'(bus_a.m_count));
    monitor(1, bus_b.m_valid, bus_b.m_ready, bus_b.s_ready, bus_b.m_hit_mask, 32'(bus_b.m_count));
  end

  initial begin
    bus_a.m_ready = 1'b0;
    bus_b.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1:       begin bus_a.m_ready = 1'b0; bus_b.m_ready = 1'b0; end
        2:       begin bus_a.m_ready = 1'b1; bus_b.m_ready = 1'b1; end
        default: begin
          bus_a.m_ready = 1'($urandom_range(0, 1));
          bus_b.m_ready = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    exp_t        e;
    bit          acc_a;
    bit          acc_b;
    int unsigned guard;
    acc_a = 1'b0;
    acc_b = 1'b0;
    guard = 0;
    @(posedge clk);
    #1;
    bus_a.s_data  = w;
    bus_b.s_data  = w;
    bus_a.s_valid = 1'b1;
    bus_b.s_valid = 1'b1;
    while (!(acc_a && acc_b)) begin
      @(negedge clk);
      if (bus_a.s_valid && bus_a.s_ready) begin
        ref_frame(w, CNT_W_A, e.mask, e.cnt);
        e.t_acc = cyc;
        exp_a.push_back(e);
        acc_a = 1'b1;
      end
      if (bus_b.s_valid && bus_b.s_ready) begin
        ref_frame(w, CNT_W_B, e.mask, e.cnt);
        e.t_acc = cyc;
        exp_b.push_back(e);
        acc_b = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_a) bus_a.s_valid = 1'b0;
      if (acc_b) bus_b.s_valid = 1'b0;
      guard++;
      if (guard > 200) begin
        checks++;
        fails++;
        $display("FAIL accept_timeout: got no acceptance expected within 200 cycles");
        bus_a.s_valid = 1'b0;
        bus_b.s_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while (exp_a.size() != 0 || exp_b.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        checks++;
        fails++;
        $display("FAIL result_timeout: got %0d/%0d pending expected 0/0", exp_a.size(), exp_b.size());
        exp_a.delete();
        exp_b.delete();
      end
    end
  endtask

  logic [DATA_W-1:0] dir_words [4] = '{8'b1010_1010, 8'b1101_0100, 8'b0000_0101, 8'h00};
  logic [3:0]        nibs      [4] = '{4'b1010, 4'b0101, 4'b1101, 4'b0100};

  initial begin
    logic [DATA_W-1:0] w;
    int unsigned       guard;

    // Reset with a pending word.
    reset         = 1'b1;
    bus_a.s_valid = 1'b1;
    bus_b.s_valid = 1'b1;
    bus_a.s_data  = 8'hAA;
    bus_b.s_data  = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      check("rst.s_ready", {31'd0, bus_a.s_ready}, 32'd0);
      check("rst.s_ready_b", {31'd0, bus_b.s_ready}, 32'd0);
      check("rst.det_reset", {31'd0, bus_a.det_reset}, 32'd1);
      check("rst.det_reset_b", {31'd0, bus_b.det_reset}, 32'd1);
      check("rst.det_in", {31'd0, bus_a.det_in}, 32'd0);
      check("rst.m_valid", {31'd0, bus_a.m_valid}, 32'd0);
      check("rst.m_hit_mask", {24'd0, bus_a.m_hit_mask}, 32'd0);
      check("rst.m_count", {28'd0, bus_a.m_count}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    @(negedge clk);
    check("post_rst.s_ready", {31'd0, bus_a.s_ready}, 32'd1);
    check("post_rst.s_ready_b", {31'd0, bus_b.s_ready}, 32'd1);
    check("post_rst.det_reset", {31'd0, bus_a.det_reset}, 32'd0);

    // Directed frames, including the two-frame carry pair.
    bp_mode = 0;
    foreach (dir_words[i]) begin
      send(dir_words[i]);
      drain();
    end

    // Backpressure: result held for 5 cycles with a competing word pending.
    bp_mode = 1;
    send(8'b0110_1010);
    guard = 0;
    while (!bus_a.m_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp.m_valid_arrived", {31'd0, bus_a.m_valid}, 32'd1);
    bus_a.s_valid = 1'b1;
    bus_b.s_valid = 1'b1;
    bus_a.s_data  = 8'hFF;
    bus_b.s_data  = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      check("bp.s_ready", {31'd0, bus_a.s_ready}, 32'd0);
      check("bp.s_ready_b", {31'd0, bus_b.s_ready}, 32'd0);
      check("bp.m_valid", {31'd0, bus_a.m_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus_a.s_valid = 1'b0;
    bus_b.s_valid = 1'b0;
    bp_mode       = 2;
    @(negedge clk);
    @(negedge clk);
    check("bp_release.s_ready", {31'd0, bus_a.s_ready}, 32'd1);
    check("bp_release.m_valid", {31'd0, bus_a.m_valid}, 32'd0);
    drain();

    // Reset in the cycle where dut_a presents bit index 4.
    bp_mode = 0;
    send(8'b1010_1010);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_a.delete();
    exp_b.delete();
    seen_a = 1'b0;
    seen_b = 1'b0;
    @(negedge clk);
    check("midrst.det_reset", {31'd0, bus_a.det_reset}, 32'd1);
    check("midrst.det_reset_b", {31'd0, bus_b.det_reset}, 32'd1);
    check("midrst.s_ready", {31'd0, bus_a.s_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_after.s_ready", {31'd0, bus_a.s_ready}, 32'd1);
    check("midrst_after.s_ready_b", {31'd0, bus_b.s_ready}, 32'd1);
    check("midrst_after.m_valid", {31'd0, bus_a.m_valid}, 32'd0);
    send(8'b1010_1010);
    drain();

    // Randomized frames, biased toward fragments of the pattern.
    for (int n = 0; n < 60; n++) begin
      if (n % 3 == 0) begin
        w = DATA_W'($urandom);
      end else begin
        w = {nibs[$urandom_range(0, 3)], nibs[$urandom_range(0, 3)]};
      end
      send(w);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: got no completion expected finish before 1000000 time units");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
